// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared select-code type and encodings for the 4-to-1 mux.
//  Contents : sel_t  - 2-bit select code type
//             SEL_D0..SEL_D3 - select codes for data inputs D0..D3
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0 = 2'b00;
  localparam sel_t SEL_D1 = 2'b01;
  localparam sel_t SEL_D2 = 2'b10;
  localparam sel_t SEL_D3 = 2'b11;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux4_1_core.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_1_core
//  Purpose  : Purely combinational WIDTH-bit 4-to-1 selector. Usable
//             stand-alone wherever an unregistered selection is needed.
//  Ports    : D0..D3 [WIDTH] in  - data inputs
//             sel    [2]     in  - select code (mux_pkg::SEL_D*)
//             y_next [WIDTH] out - selected word
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y_next
);

  // All four codes are legal. The all-X pre-assignment is only ever kept
  // when sel itself is X/Z in simulation, so an unknown select shows up as
  // an unknown word instead of silently falling back to D0. In synthesis
  // it is a don't-care and never blocks a full-case mapping.
  always_comb begin
    y_next = {WIDTH{1'bx}};
    case (sel)
      SEL_D0: y_next = D0;
      SEL_D1: y_next = D1;
      SEL_D2: y_next = D2;
      SEL_D3: y_next = D3;
    endcase
  end

endmodule : mux4_1_core
`default_nettype wire

// File: rtl/mux4_to_1.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_to_1
//  Purpose  : Registered 4-to-1 multiplexer for the ALU datapath. The core
//             selector picks one of D0..D3; the result is captured in an
//             output register when en = 1, and y_valid flags a fresh load.
//  Ports    : clk            in  - rising-edge clock
//             rst            in  - synchronous active-high reset
//             D0..D3 [WIDTH] in  - data inputs
//             sel    [2]     in  - select code
//             en             in  - load enable
//             Y      [WIDTH] out - registered selected word
//             y_valid        out - high for one cycle after each load
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  sel_t             sel,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid
);

  logic [WIDTH-1:0] w_y_next;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             valid_d;
  logic             valid_q;

  mux4_1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .D0     (D0),
    .D1     (D1),
    .D2     (D2),
    .D3     (D3),
    .sel    (sel),
    .y_next (w_y_next)
  );

  // Load on en, otherwise hold the word; valid is a one-cycle pulse that
  // is only raised by an actual load.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (en) begin
      y_d     = w_y_next;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Y       = y_q;
  assign y_valid = valid_q;

endmodule : mux4_to_1
`default_nettype wire

// File: tb/tb_mux4_to_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_to_1
//  Purpose  : Self-checking bench for mux4_to_1 (WIDTH = 4). A directed
//             vector table covers reset, select sweep, hold, data change and
//             mid-stream reset; a randomized phase compares the core output
//             and the registered output against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_to_1;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] D0, D1, D2, D3;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] Y;
  logic             y_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_to_1 #(
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .D0      (D0),
    .D1      (D1),
    .D2      (D2),
    .D3      (D3),
    .sel     (sel),
    .en      (en),
    .Y       (Y),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                  rst;
    logic                  en;
    logic [1:0]            sel;
    logic [3:0][WIDTH-1:0] d;      // d[0] = D0 ... d[3] = D3
    logic [WIDTH-1:0]      exp_y;
    logic                  exp_v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] s,
                       input logic [3:0][WIDTH-1:0] d);
    rst = r;
    en  = e;
    sel = s;
    D0  = d[0];
    D1  = d[1];
    D2  = d[2];
    D3  = d[3];
  endtask

  vec_t vecs[16];

  // Reference model state for the random phase.
  logic [WIDTH-1:0] m_y;
  logic             m_v;

  initial begin
    logic [3:0][WIDTH-1:0] base;
    logic [3:0][WIDTH-1:0] chg;
    logic [3:0][WIDTH-1:0] rd;
    logic                  rr;
    logic                  re;
    logic [1:0]            rs;

    base = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    chg  = base;
    chg[1] = 4'b1111;

    //          rst   en    sel    d     exp_y    exp_v
    vecs[0]  = '{1'b1, 1'b1, 2'b11, base, 4'b0000, 1'b0};  // reset, 2 cycles
    vecs[1]  = '{1'b1, 1'b1, 2'b11, base, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, base, 4'b0001, 1'b1};  // select sweep
    vecs[3]  = '{1'b0, 1'b1, 2'b01, base, 4'b0010, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, base, 4'b0100, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, base, 4'b1000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, base, 4'b0100, 1'b1};  // hold: load D2
    vecs[7]  = '{1'b0, 1'b0, 2'b11, base, 4'b0100, 1'b0};  // then en = 0
    vecs[8]  = '{1'b0, 1'b0, 2'b11, base, 4'b0100, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b11, base, 4'b0100, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'b01, base, 4'b0010, 1'b1};  // data change
    vecs[11] = '{1'b0, 1'b1, 2'b01, chg,  4'b1111, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'b00, base, 4'b0001, 1'b1};  // sweep + reset
    vecs[13] = '{1'b0, 1'b1, 2'b01, base, 4'b0010, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 2'b10, base, 4'b0000, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'b11, base, 4'b1000, 1'b1};

    drive(1'b1, 1'b0, 2'b00, base);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].d);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_Y", i), 32'(Y), 32'(vecs[i].exp_y));
      check($sformatf("vec%0d_y_valid", i), 32'(y_valid), 32'(vecs[i].exp_v));
      @(negedge clk);
    end

    // Randomized phase: model the register from the selection rules.
    drive(1'b1, 1'b0, 2'b00, base);
    @(posedge clk);
    #1;
    m_y = '0;
    m_v = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) rd[k] = WIDTH'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      re = ($urandom_range(0, 3) != 0);
      rs = 2'($urandom);
      drive(rr, re, rs, rd);
      #1;
      check("core_y_next", 32'(dut.u_core.y_next), 32'(rd[rs]));
      if (rr) begin
        m_y = '0;
        m_v = 1'b0;
      end else if (re) begin
        m_y = rd[rs];
        m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      @(posedge clk);
      #1;
      check("rand_Y", 32'(Y), 32'(m_y));
      check("rand_y_valid", 32'(y_valid), 32'(m_v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux4_to_1
`default_nettype wire
